// File: rtl/pwm_duty_meter_pkg.sv
// Shared definitions for the PWM duty meter: default widths, FSM encoding and
// the percentage scale used by the duty computation.
package pwm_duty_meter_pkg;

  localparam int CNT_W_DEFAULT = 27;
  localparam int DIV_STEPS     = CNT_W_DEFAULT + 7;
  localparam int PCT_MAX       = 100;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DIVIDE  = 2'd2
  } state_t;

  function automatic int div_steps(input int cnt_w);
    return cnt_w + 7;
  endfunction

endpackage

// File: rtl/edge_detector_p.sv
// Rise/fall strobe generator for an already-synchronized level.
module edge_detector_p (
  input  logic clk,
  input  logic rstp,
  input  logic d,
  output logic p_edge,
  output logic n_edge
);

  logic d_q;

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) d_q <= 1'b0;
    else      d_q <= d;
  end

  assign p_edge = d & ~d_q;
  assign n_edge = ~d & d_q;

endmodule

// File: rtl/pwm_seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle; done pulses for one
// cycle once all bits are resolved, abort returns it to idle at once.
module pwm_seq_divider
  import pwm_duty_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rstp,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_W+6:0]     dividend,
  input  logic [CNT_W-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W+6:0]     quotient
);

  localparam int DW    = CNT_W + 7;
  localparam int STEPS = div_steps(CNT_W);
  localparam int SW    = $clog2(STEPS + 1);

  logic [SW-1:0]    step_cnt;
  logic [CNT_W-1:0] rem_p0;
  logic [DW-1:0]    quo_p0;
  logic [CNT_W-1:0] dvs_p0;
  logic [CNT_W:0]   rem_sh;
  logic [CNT_W:0]   diff;
  logic             q_bit;
  logic [CNT_W-1:0] rem_nxt;

  always_comb begin
    rem_sh  = {rem_p0, quo_p0[DW-1]};
    diff    = rem_sh - {1'b0, dvs_p0};
    q_bit   = ~diff[CNT_W];
    rem_nxt = q_bit ? diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      step_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        busy <= 1'b0;
      end else if (start) begin
        busy     <= 1'b1;
        step_cnt <= SW'(STEPS);
      end else if (busy) begin
        step_cnt <= step_cnt - SW'(1);
        if (step_cnt == SW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  // iteration stage: shift-subtract on the partial remainder
  always_ff @(posedge clk) begin
    if (start) begin
      rem_p0 <= '0;
      quo_p0 <= dividend;
      dvs_p0 <= divisor;
    end else if (busy) begin
      rem_p0 <= rem_nxt;
      quo_p0 <= {quo_p0[DW-2:0], q_bit};
    end
  end

  assign quotient = quo_p0;

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures an external PWM input: period and high time in clk cycles plus duty
// in percent, with a no-signal timeout that reports the stuck level.
module pwm_duty_meter
  import pwm_duty_meter_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 125_000_000,
  parameter int CNT_W        = CNT_W_DEFAULT,
  parameter int TIMEOUT_CYC  = SYS_CLK_FREQ / 10
) (
  input  logic             clk,
  input  logic             rstp,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic [6:0]       duty_pc,
  output logic             valid,
  output logic             no_signal,
  output logic             level
);

  localparam int DW = CNT_W + 7;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

  function automatic logic [6:0] clamp_pct(input logic [DW-1:0] q);
    if (q > DW'(PCT_MAX)) return 7'(PCT_MAX);
    return q[6:0];
  endfunction

  logic             sync_p0, sync_p1;
  logic             rise, fall;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] counter, high_lat;
  logic [CNT_W-1:0] snap_period, snap_high;
  logic             timeout_hit;
  logic             cnt_restart, div_start, div_abort, do_timeout, do_publish;
  logic             div_busy, div_done;
  logic [DW-1:0]    dividend, quotient;

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= pwm_in;
      sync_p1 <= sync_p0;
    end
  end

  edge_detector_p u_edge (
    .clk    (clk),
    .rstp   (rstp),
    .d      (sync_p1),
    .p_edge (rise),
    .n_edge (fall)
  );

  assign timeout_hit = (counter == TIMEOUT_VAL);

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // A rise while the divider is busy restarts counting but takes no snapshot.
  always_comb begin
    state_nxt   = state;
    cnt_restart = 1'b0;
    div_start   = 1'b0;
    div_abort   = 1'b0;
    do_timeout  = 1'b0;
    do_publish  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          cnt_restart = 1'b1;
          state_nxt   = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (timeout_hit) begin
          do_timeout = 1'b1;
          state_nxt  = ST_IDLE;
        end else if (rise) begin
          cnt_restart = 1'b1;
          div_start   = 1'b1;
          state_nxt   = ST_DIVIDE;
        end
      end
      ST_DIVIDE: begin
        if (timeout_hit) begin
          do_timeout = 1'b1;
          div_abort  = div_busy;
          state_nxt  = ST_IDLE;
        end else begin
          cnt_restart = rise;
          if (div_done) begin
            do_publish = 1'b1;
            state_nxt  = ST_MEASURE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      counter  <= '0;
      high_lat <= '0;
    end else begin
      if (do_timeout)
        counter <= '0;
      else if (cnt_restart)
        counter <= CNT_W'(1);
      else if (state != ST_IDLE && counter != TIMEOUT_VAL)
        counter <= counter + CNT_W'(1);

      if (cnt_restart)
        high_lat <= '0;
      else if (fall && state != ST_IDLE)
        high_lat <= counter;
    end
  end

  // snapshot stage: hold the closed period while the divider runs
  always_ff @(posedge clk) begin
    if (div_start) begin
      snap_period <= counter;
      snap_high   <= high_lat;
    end
  end

  assign dividend = {7'd0, high_lat} * DW'(PCT_MAX);

  pwm_seq_divider #(.CNT_W(CNT_W)) u_div (
    .clk      (clk),
    .rstp     (rstp),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (dividend),
    .divisor  (counter),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  // publish stage: measurement result or timeout report
  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      period_cnt <= '0;
      high_cnt   <= '0;
      duty_pc    <= '0;
      valid      <= 1'b0;
      no_signal  <= 1'b0;
      level      <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (do_timeout) begin
        period_cnt <= '0;
        high_cnt   <= '0;
        duty_pc    <= sync_p1 ? 7'(PCT_MAX) : 7'd0;
        level      <= sync_p1;
        no_signal  <= 1'b1;
        valid      <= 1'b1;
      end else if (do_publish) begin
        period_cnt <= snap_period;
        high_cnt   <= snap_high;
        duty_pc    <= clamp_pct(quotient);
        no_signal  <= 1'b0;
        valid      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter with a shortened timeout so the stuck-input
// cases fit in a short run.
module tb_pwm_duty_meter;

  localparam int CNT_W   = 27;
  localparam int TIMEOUT = 5000;

  logic             clk = 1'b0;
  logic             rstp;
  logic             pwm_in;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [6:0]       duty_pc;
  logic             valid;
  logic             no_signal;
  logic             level;

  pwm_duty_meter #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rstp       (rstp),
    .pwm_in     (pwm_in),
    .period_cnt (period_cnt),
    .high_cnt   (high_cnt),
    .duty_pc    (duty_pc),
    .valid      (valid),
    .no_signal  (no_signal),
    .level      (level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Valid-pulse monitor; counts cumulatively so the main sequence only reads it.
  int               valid_total = 0;
  int               bad_total   = 0;
  int               last_valid_cyc = 0;
  logic [6:0]       mon_exp_duty = 7'd0;
  logic [CNT_W-1:0] last_period = '0;
  logic [CNT_W-1:0] last_high = '0;
  logic [6:0]       last_duty = '0;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_total    <= valid_total + 1;
      last_valid_cyc <= cyc;
      last_period    <= period_cnt;
      last_high      <= high_cnt;
      last_duty      <= duty_pc;
      if (duty_pc !== mon_exp_duty) bad_total <= bad_total + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int vbase, bbase, t_rise;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pwm_run(input int period, input int high, input int n);
    repeat (n) begin
      pwm_in = 1'b1;
      cycles(high);
      pwm_in = 1'b0;
      cycles(period - high);
    end
  endtask

  task automatic do_reset();
    rstp = 1'b1;
    cycles(3);
    rstp = 1'b0;
    cycles(3);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, 64'(period_cnt), 64'd0);
    check({tag, "_high"},   64'(high_cnt),   64'd0);
    check({tag, "_duty"},   64'(duty_pc),    64'd0);
    check({tag, "_valid"},  64'(valid),      64'd0);
  endtask

  initial begin
    rstp   = 1'b1;
    pwm_in = 1'b0;
    cycles(3);
    check_zero("rst");
    check("rst_nosig", 64'(no_signal), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    rstp = 1'b0;
    cycles(5);

    // 50% at 1000 cycles; sync (2) + edge register (1) + 35 cycles to valid
    mon_exp_duty = 7'd50;
    vbase = valid_total; bbase = bad_total;
    pwm_run(1000, 500, 1);
    pwm_in = 1'b1;
    t_rise = cyc;
    cycles(40);
    check("p50_first_cnt", 64'(valid_total - vbase), 64'd1);
    check("p50_latency", 64'(last_valid_cyc - t_rise), 64'd38);
    cycles(460);
    pwm_in = 1'b0;
    cycles(500);
    pwm_run(1000, 500, 1);
    cycles(40);
    check("p50_cnt", 64'(valid_total - vbase), 64'd2);
    check("p50_period", 64'(last_period), 64'd1000);
    check("p50_high", 64'(last_high), 64'd500);
    check("p50_duty", 64'(last_duty), 64'd50);
    check("p50_nosig", 64'(no_signal), 64'd0);
    check("p50_steady", 64'(bad_total - bbase), 64'd0);

    // reset asserted mid-period clears outputs without waiting for a clock
    rstp = 1'b1;
    #1;
    check_zero("rst_mid");
    cycles(3);
    rstp = 1'b0;
    cycles(3);

    // 25% at 400 cycles
    mon_exp_duty = 7'd25;
    vbase = valid_total; bbase = bad_total;
    pwm_run(400, 100, 4);
    cycles(40);
    check("p25_cnt", 64'(valid_total - vbase), 64'd3);
    check("p25_period", 64'(last_period), 64'd400);
    check("p25_high", 64'(last_high), 64'd100);
    check("p25_duty", 64'(last_duty), 64'd25);
    check("p25_steady", 64'(bad_total - bbase), 64'd0);

    // 73%: 91400/1252 = 73.003 -> 73
    do_reset();
    mon_exp_duty = 7'd73;
    vbase = valid_total; bbase = bad_total;
    pwm_run(1252, 914, 6);
    cycles(40);
    check("p73_cnt", 64'(valid_total - vbase), 64'd5);
    check("p73_period", 64'(last_period), 64'd1252);
    check("p73_high", 64'(last_high), 64'd914);
    check("p73_duty", 64'(last_duty), 64'd73);
    check("p73_steady", 64'(bad_total - bbase), 64'd0);

    // 20-cycle period: every other period falls inside a division and is dropped
    do_reset();
    mon_exp_duty = 7'd50;
    vbase = valid_total; bbase = bad_total;
    pwm_run(20, 10, 10);
    cycles(50);
    check("p20_cnt", 64'(valid_total - vbase), 64'd5);
    check("p20_period", 64'(last_period), 64'd20);
    check("p20_high", 64'(last_high), 64'd10);
    check("p20_duty", 64'(last_duty), 64'd50);
    check("p20_steady", 64'(bad_total - bbase), 64'd0);

    // input stuck low after activity
    vbase = valid_total;
    cycles(TIMEOUT + 200);
    check("to0_cnt", 64'(valid_total - vbase), 64'd1);
    check("to0_nosig", 64'(no_signal), 64'd1);
    check("to0_level", 64'(level), 64'd0);
    check("to0_duty", 64'(duty_pc), 64'd0);
    check("to0_period", 64'(period_cnt), 64'd0);
    check("to0_high", 64'(high_cnt), 64'd0);

    // input stuck high: one measurement closes, then the timeout report
    do_reset();
    pwm_run(1000, 500, 1);
    pwm_in = 1'b1;
    vbase = valid_total;
    cycles(TIMEOUT + 200);
    check("to1_cnt", 64'(valid_total - vbase), 64'd2);
    check("to1_nosig", 64'(no_signal), 64'd1);
    check("to1_level", 64'(level), 64'd1);
    check("to1_duty", 64'(duty_pc), 64'd100);
    check("to1_period", 64'(period_cnt), 64'd0);

    // no_signal holds until a complete measurement
    pwm_in = 1'b0;
    cycles(500);
    pwm_run(1000, 500, 1);
    pwm_in = 1'b1;
    cycles(20);
    check("recov_hold", 64'(no_signal), 64'd1);
    cycles(20);
    check("recov_nosig", 64'(no_signal), 64'd0);
    check("recov_duty", 64'(duty_pc), 64'd50);
    check("recov_period", 64'(period_cnt), 64'd1000);

    // reset during a division: no result, then two fresh rises needed
    cycles(460);
    pwm_in = 1'b0;
    cycles(500);
    pwm_in = 1'b1;
    cycles(10);
    rstp = 1'b1;
    #1;
    check_zero("rst_div");
    check("rst_div_nosig", 64'(no_signal), 64'd0);
    pwm_in = 1'b0;
    cycles(5);
    rstp = 1'b0;
    vbase = valid_total;
    cycles(50);
    check("rst_div_quiet", 64'(valid_total - vbase), 64'd0);
    pwm_run(1000, 500, 1);
    check("rst_div_one_rise", 64'(valid_total - vbase), 64'd0);
    pwm_in = 1'b1;
    cycles(40);
    check("rst_div_cnt", 64'(valid_total - vbase), 64'd1);
    check("rst_div_period", 64'(period_cnt), 64'd1000);
    check("rst_div_duty", 64'(duty_pc), 64'd50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
